mem_rmw_ctrl: RTL and testbench
===============================

// Module: mem_rmw_ctrl
// PURPOSE
//  Data-memory controller between the PROCESSOR data port and a word-wide synchronous SRAM.
//  Passes aligned word loads and stores through to the SRAM.
//  Implements MIPS SWL/SWR partial stores as a read-modify-write sequence, using big-endian byte lanes.
//  Stalls the processor MEM stage until each access completes.
// PARAMETERS
//  ADDR_W  16  processor byte-address width; SRAM word address is ADDR_W-2 bits (data fixed at 32 bits)
// PORTS
//  Clock       in   1       single clock, rising edge
//  Reset       in   1       asynchronous, active-high
//  Address     in   ADDR_W  processor byte address
//  ReadEn      in   1       load request
//  WriteEn     in   1       store request
//  WriteL      in   1       qualifies WriteEn as SWL
//  WriteR      in   1       qualifies WriteEn as SWR
//  WriteData   in   32      store data (rt)
//  ReadData    out  32      load data
//  Stall       out  1       processor must hold its request while high
//  MemAddr     out  ADDR_W-2  SRAM word address
//  MemReadEn   out  1       SRAM read strobe; data returns on MemRData in the next cycle
//  MemWriteEn  out  1       SRAM write strobe
//  MemWData    out  32      SRAM write data
//  MemRData    in   32      SRAM read data
// BEHAVIOUR
//  Reset: state IDLE; ReadData=0; Stall, MemReadEn, MemWriteEn, MemWData and MemAddr all 0.
//   Reset asserted mid-sequence aborts to IDLE; no SRAM write is issued afterwards.
//  Decoded outputs are combinational from state and request. MemAddr=Address[ADDR_W-1:2].
//  Priority: WriteEn over ReadEn; WriteL over WriteR.
//  FSM states and transitions:
//   IDLE
//    - full store (WriteEn, !WriteL, !WriteR): MemWriteEn=1, MemWData=WriteData, Stall=0, stay in IDLE
//    - load: MemReadEn=1, Stall=1, go to LD_DONE
//    - WriteL or WriteR: MemReadEn=1, Stall=1; latch b=Address[1:0], kind, WriteData and word address; go to RMW
//   LD_DONE
//    - ReadData=MemRData combinationally, Stall=0
//    - ReadData register captures MemRData at this edge and holds the value until the next LD_DONE
//    - go to IDLE
//   RMW
//    - MemWriteEn=1, MemAddr=latched address, MemWData=merge(MemRData), Stall=1
//    - go to DONE
//   DONE
//    - Stall=0, no SRAM strobes; the processor advances on this edge
//    - go to IDLE; a held request is not re-issued
//  Merge rules (lane 0 = bits[31:24]):
//   - SWL: (mem & ~(32'hFFFFFFFF >> 8b)) | (rt >> 8b)
//   - SWR: (mem & ~(32'hFFFFFFFF << 8(3-b))) | (rt << 8(3-b))
//   - SWL with b=0 and SWR with b=3 still take the full 3-cycle RMW path.
//  Latency: full store 1 cycle, 0 stall; load 2 cycles, 1 stall; SWL/SWR 3 cycles, 2 stalls.
//  Back-to-back requests: the next request is accepted in the IDLE that follows LD_DONE or DONE.
// CONFIGURATION
//  MEMCTRL_ALIGN_CHECK_EN defined:
//   - adds output AlignErr (1 bit, reset 0)
//   - a load or full store with Address[1:0]!=0 sets AlignErr, which stays set until Reset
//   - the offending access issues no SRAM strobe; a load completes via LD_DONE with ReadData=0
//  Macro undefined: no AlignErr port; Address[1:0] is ignored for full-word accesses.
// STRUCTURE
//  Package mem_ctrl_pkg: state enum {IDLE, LD_DONE, RMW, DONE}; req_kind_t {SWL, SWR}; lane-mask functions.
//  Sub-module mem_byte_merge (combinational): inputs kind, b, mem word, rt; output merged word.
// TESTING
//  - Reset: hold Reset, drive WriteEn -> Stall=0, MemWriteEn=0, ReadData=0.
//  - Full store: Address=16'h0010, WriteData=32'h11223344 -> MemWriteEn=1 one cycle, MemAddr=14'h0004, Stall never 1.
//  - Load of word 0x0010 -> 1 stall cycle; ReadData=32'h11223344 in LD_DONE and held afterwards.
//  - SWL: Address=16'h0011, rt=32'hAABBCCDD, mem=32'h11223344 -> 2 stall cycles; SRAM write 32'h11AABBCC to word 4.
//  - SWR: same Address and rt -> SRAM write 32'hCCDD3344; back-to-back SWL then SWR -> both writes land, in order.
//  - Reset asserted during RMW -> no MemWriteEn; word 4 keeps its old value; Stall=0.
//  - With MEMCTRL_ALIGN_CHECK_EN, load at 16'h0012 -> AlignErr=1 (sticky), MemReadEn stays 0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and lane-mask helpers for the data-memory RMW controller.
// Lane 0 is the most significant byte (big-endian), so byte offset b maps to bits [31-8b -: 8].
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LD_DONE,
        RMW,
        DONE
    } state_t;

    typedef enum logic {
        SWL,
        SWR
    } req_kind_t;

    localparam int DATA_W = 32;

    // Lanes that an SWL at byte offset b takes from rt: lanes b..3.
    function automatic logic [DATA_W-1:0] swlMask(input logic [1:0] b);
        return 32'hFFFF_FFFF >> {b, 3'b000};
    endfunction

    // Lanes that an SWR at byte offset b takes from rt: lanes 0..b.
    // The shift amount 3-b is the bitwise inverse of a 2-bit b.
    function automatic logic [DATA_W-1:0] swrMask(input logic [1:0] b);
        return 32'hFFFF_FFFF << {~b, 3'b000};
    endfunction

endpackage

// File: rtl/mem_byte_merge.sv
// Combinational SWL/SWR merge of register data into the word read back from SRAM.
module mem_byte_merge
    import mem_ctrl_pkg::*;
(
    input  req_kind_t          kind,
    input  logic [1:0]         b,
    input  logic [DATA_W-1:0]  memWord,
    input  logic [DATA_W-1:0]  rt,
    output logic [DATA_W-1:0]  merged
);

    // Keep the untouched lanes of the memory word and shift rt into the remaining ones.
    always_comb begin
        if (kind == SWL) begin
            merged = (memWord & ~swlMask(b)) | (rt >> {b, 3'b000});
        end else begin
            merged = (memWord & ~swrMask(b)) | (rt << {~b, 3'b000});
        end
    end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// Data-memory controller: word loads/stores pass through to a synchronous SRAM,
// SWL/SWR are done as read-modify-write, and Stall holds the MEM stage meanwhile.
// Optional feature: define MEMCTRL_ALIGN_CHECK_EN to add the sticky AlignErr output
// and suppress SRAM strobes for misaligned full-word accesses.
module mem_rmw_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Address,
    input  logic              ReadEn,
    input  logic              WriteEn,
    input  logic              WriteL,
    input  logic              WriteR,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              Stall,
`ifdef MEMCTRL_ALIGN_CHECK_EN
    output logic              AlignErr,
`endif
    output logic [ADDR_W-3:0] MemAddr,
    output logic              MemReadEn,
    output logic              MemWriteEn,
    output logic [31:0]       MemWData,
    input  logic [31:0]       MemRData
);

    state_t            state;
    state_t            nextState;

    req_kind_t         rmwKind;
    logic [1:0]        rmwB;
    logic [31:0]       rmwData;
    logic [ADDR_W-3:0] rmwAddr;
    logic              captureRmw;

    logic [31:0]       readDataReg;
    logic [31:0]       loadValue;
    logic [31:0]       mergedWord;

    logic              ldFault;
    logic              misaligned;
    logic              setAlign;
    logic              alignErrReg;

    // Request decode; WriteEn wins over ReadEn, WriteL over WriteR.
    logic isFullStore;
    logic isPartial;
    logic isLoad;

    assign isFullStore = WriteEn & ~WriteL & ~WriteR;
    assign isPartial   = WriteEn & (WriteL | WriteR);
    assign isLoad      = ~WriteEn & ReadEn;

`ifdef MEMCTRL_ALIGN_CHECK_EN
    assign misaligned = |Address[1:0];
    assign AlignErr   = alignErrReg;
`else
    assign misaligned = 1'b0;
`endif

    // A faulted load returns zero instead of whatever the SRAM drives.
    assign loadValue = ldFault ? 32'h0 : MemRData;

    mem_byte_merge uMerge (
        .kind    (rmwKind),
        .b       (rmwB),
        .memWord (MemRData),
        .rt      (rmwData),
        .merged  (mergedWord)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and decoded SRAM/processor outputs.
    always_comb begin
        // NOTE: every output gets a default up front so no branch can infer a latch.
        nextState  = state;
        Stall      = 1'b0;
        MemReadEn  = 1'b0;
        MemWriteEn = 1'b0;
        MemWData   = 32'h0;
        MemAddr    = Address[ADDR_W-1:2];
        ReadData   = readDataReg;
        captureRmw = 1'b0;
        setAlign   = 1'b0;

        case (state)
            IDLE: begin
                if (isFullStore) begin
                    if (misaligned) begin
                        setAlign = 1'b1;
                    end else begin
                        MemWriteEn = 1'b1;
                        MemWData   = WriteData;
                    end
                end else if (isPartial) begin
                    MemReadEn  = 1'b1;
                    Stall      = 1'b1;
                    captureRmw = 1'b1;
                    nextState  = RMW;
                end else if (isLoad) begin
                    MemReadEn = ~misaligned;
                    setAlign  = misaligned;
                    Stall     = 1'b1;
                    nextState = LD_DONE;
                end
            end
            LD_DONE: begin
                ReadData  = loadValue;
                nextState = IDLE;
            end
            RMW: begin
                MemWriteEn = 1'b1;
                MemAddr    = rmwAddr;
                MemWData   = mergedWord;
                Stall      = 1'b1;
                nextState  = DONE;
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        // Reset overrides request decode so nothing reaches the SRAM while it is held.
        if (Reset) begin
            Stall      = 1'b0;
            MemReadEn  = 1'b0;
            MemWriteEn = 1'b0;
            MemWData   = 32'h0;
            MemAddr    = '0;
            ReadData   = 32'h0;
            captureRmw = 1'b0;
            setAlign   = 1'b0;
        end
    end

    // Capture the partial-store context while the SRAM read is in flight.
    // NOTE: these datapath registers are always loaded before RMW reads them, so they need no reset.
    always_ff @(posedge Clock) begin
        if (captureRmw) begin
            rmwKind <= WriteL ? SWL : SWR;
            rmwB    <= Address[1:0];
            rmwData <= WriteData;
            rmwAddr <= Address[ADDR_W-1:2];
        end
    end

    // Load result register: updated only when a load completes, held otherwise.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            readDataReg <= 32'h0;
            ldFault     <= 1'b0;
        end else begin
            if (state == IDLE && isLoad) begin
                ldFault <= misaligned;
            end
            if (state == LD_DONE) begin
                readDataReg <= loadValue;
            end
        end
    end

    // Sticky alignment error, cleared only by Reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            alignErrReg <= 1'b0;
        end else if (setAlign) begin
            alignErrReg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Self-checking bench for mem_rmw_ctrl: a small SRAM model answers the controller,
// expected SRAM writes are queued when stimulus is driven and popped as writes appear.
module tb_mem_rmw_ctrl;

    localparam int ADDR_W = 16;

    logic              Clock;
    logic              Reset;
    logic [ADDR_W-1:0] Address;
    logic              ReadEn;
    logic              WriteEn;
    logic              WriteL;
    logic              WriteR;
    logic [31:0]       WriteData;
    logic [31:0]       ReadData;
    logic              Stall;
`ifdef MEMCTRL_ALIGN_CHECK_EN
    logic              AlignErr;
`endif
    logic [ADDR_W-3:0] MemAddr;
    logic              MemReadEn;
    logic              MemWriteEn;
    logic [31:0]       MemWData;
    logic [31:0]       MemRData;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [ADDR_W-3:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         wrQ[$];
    logic [31:0] sram   [0:63];
    logic [31:0] refMem [0:63];

    mem_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Address    (Address),
        .ReadEn     (ReadEn),
        .WriteEn    (WriteEn),
        .WriteL     (WriteL),
        .WriteR     (WriteR),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .Stall      (Stall),
`ifdef MEMCTRL_ALIGN_CHECK_EN
        .AlignErr   (AlignErr),
`endif
        .MemAddr    (MemAddr),
        .MemReadEn  (MemReadEn),
        .MemWriteEn (MemWriteEn),
        .MemWData   (MemWData),
        .MemRData   (MemRData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Synchronous SRAM model: one-cycle read latency.
    always @(posedge Clock) begin
        if (MemWriteEn === 1'b1) sram[MemAddr[5:0]] <= MemWData;
        if (MemReadEn === 1'b1)  MemRData <= sram[MemAddr[5:0]];
    end

    // Write monitor: every SRAM write must match the next queued expectation.
    always @(negedge Clock) begin
        if (MemWriteEn === 1'b1) begin
            compared++;
            if (wrQ.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_write: addr=%h data=%h, none expected", MemAddr, MemWData);
            end else begin
                wr_t e;
                e = wrQ.pop_front();
                if (MemAddr !== e.addr || MemWData !== e.data) begin
                    mismatched++;
                    $display("FAIL sram_write: got addr=%h data=%h, expected addr=%h data=%h",
                             MemAddr, MemWData, e.addr, e.data);
                end
            end
        end
    end

    // Byte-lane reference model of SWL/SWR (lane 0 = bits 31:24).
    function automatic logic [31:0] modelMerge(input bit isL, input logic [1:0] b,
                                               input logic [31:0] m, input logic [31:0] rt);
        logic [7:0]  ml [4];
        logic [7:0]  rl [4];
        logic [31:0] res;
        int          bi;
        bi = int'(b);
        for (int i = 0; i < 4; i++) begin
            ml[i] = m[31-8*i -: 8];
            rl[i] = rt[31-8*i -: 8];
        end
        res = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (isL) res[31-8*i -: 8] = (i < bi)  ? ml[i] : rl[i-bi];
            else     res[31-8*i -: 8] = (i <= bi) ? rl[i+3-bi] : ml[i];
        end
        return res;
    endfunction

    // Drive one request (kind 0 load, 1 store, 2 SWL, 3 SWR) and hold it until Stall drops.
    // Entered and left at 1 ns after a rising edge, so consecutive calls are back-to-back.
    task automatic doAccess(input int kind, input logic [15:0] addr, input logic [31:0] data,
                            output int stalls, output logic [31:0] rdata, output logic firstRd);
        bit done;
        if (kind != 0) begin
            wr_t e;
            e.addr = addr[ADDR_W-1:2];
            if (kind == 1) e.data = data;
            else           e.data = modelMerge(kind == 2, addr[1:0], refMem[addr[7:2]], data);
            wrQ.push_back(e);
            refMem[addr[7:2]] = e.data;
        end
        Address   = addr;
        WriteData = data;
        ReadEn    = (kind == 0);
        WriteEn   = (kind != 0);
        WriteL    = (kind == 2);
        WriteR    = (kind == 3);
        stalls    = 0;
        rdata     = 'x;
        firstRd   = 1'b0;
        done      = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge Clock);
            if (cyc == 0) firstRd = MemReadEn;
            if (Stall === 1'b0) begin
                rdata = ReadData;
                done  = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge Clock);
            #1;
            if (done) break;
        end
        ReadEn  = 1'b0;
        WriteEn = 1'b0;
        WriteL  = 1'b0;
        WriteR  = 1'b0;
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL access_timeout: kind=%0d addr=%h still stalled after 8 cycles", kind, addr);
        end
    endtask

    task automatic checkDrained(input string name);
        compared++;
        if (wrQ.size() != 0) begin
            mismatched++;
            $display("FAIL %s_writes_missing: %0d expected SRAM writes never seen", name, wrQ.size());
            wrQ.delete();
        end
    endtask

    // Load a word and compare against a bench-computed value.
    task automatic checkWord(input string name, input logic [15:0] addr, input logic [31:0] exp);
        int          st;
        logic [31:0] rd;
        logic        fr;
        doAccess(0, addr, 32'h0, st, rd, fr);
        compared++;
        if (st != 1 || rd !== exp || fr !== 1'b1) begin
            mismatched++;
            $display("FAIL %s: stalls=%0d data=%h rd_strobe=%b, expected stalls=1 data=%h rd_strobe=1",
                     name, st, rd, fr, exp);
        end
    endtask

    task automatic test_reset();
        Reset     = 1'b1;
        WriteEn   = 1'b1;
        Address   = 16'h0010;
        WriteData = 32'hDEADBEEF;
        @(negedge Clock);
        compared++;
        if (Stall !== 1'b0 || MemWriteEn !== 1'b0 || MemReadEn !== 1'b0 ||
            ReadData !== 32'h0 || MemAddr !== '0 || MemWData !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_outputs: Stall=%b MemWriteEn=%b MemReadEn=%b ReadData=%h MemAddr=%h MemWData=%h, expected all 0",
                     Stall, MemWriteEn, MemReadEn, ReadData, MemAddr, MemWData);
        end
        WriteEn = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_full_store();
        int          st;
        logic [31:0] rd;
        logic        fr;
        doAccess(1, 16'h0010, 32'h11223344, st, rd, fr);
        compared++;
        if (st != 0 || fr !== 1'b0) begin
            mismatched++;
            $display("FAIL full_store_latency: stalls=%0d rd_strobe=%b, expected stalls=0 rd_strobe=0", st, fr);
        end
        checkDrained("full_store");
    endtask

    task automatic test_load();
        checkWord("load_word4", 16'h0010, 32'h11223344);
        @(negedge Clock);
        compared++;
        if (ReadData !== 32'h11223344 || Stall !== 1'b0) begin
            mismatched++;
            $display("FAIL load_hold: ReadData=%h Stall=%b, expected 11223344 and 0", ReadData, Stall);
        end
        @(posedge Clock);
        #1;
        checkDrained("load");
    endtask

    task automatic test_swl();
        int          st;
        logic [31:0] rd;
        logic        fr;
        doAccess(2, 16'h0011, 32'hAABBCCDD, st, rd, fr);
        compared++;
        if (st != 2 || fr !== 1'b1) begin
            mismatched++;
            $display("FAIL swl_latency: stalls=%0d rd_strobe=%b, expected 2 and 1", st, fr);
        end
        checkDrained("swl");
        checkWord("swl_result", 16'h0010, 32'h11AABBCC);
    endtask

    task automatic test_swr();
        int          st;
        logic [31:0] rd;
        logic        fr;
        doAccess(1, 16'h0010, 32'h11223344, st, rd, fr);
        doAccess(3, 16'h0011, 32'hAABBCCDD, st, rd, fr);
        compared++;
        if (st != 2) begin
            mismatched++;
            $display("FAIL swr_latency: stalls=%0d, expected 2", st);
        end
        checkDrained("swr");
        checkWord("swr_result", 16'h0010, 32'hCCDD3344);
    endtask

    task automatic test_back_to_back();
        int          st;
        logic [31:0] rd;
        logic        fr;
        doAccess(1, 16'h0010, 32'h11223344, st, rd, fr);
        doAccess(2, 16'h0011, 32'hAABBCCDD, st, rd, fr);
        doAccess(3, 16'h0011, 32'hAABBCCDD, st, rd, fr);
        checkDrained("back_to_back");
        checkWord("back_to_back_result", 16'h0010, 32'hCCDDBBCC);
    endtask

    task automatic test_boundary();
        int          st;
        logic [31:0] rd;
        logic        fr;
        logic [31:0] rt;
        doAccess(1, 16'h0020, 32'h55667788, st, rd, fr);
        doAccess(2, 16'h0020, 32'h01020304, st, rd, fr);
        compared++;
        if (st != 2) begin
            mismatched++;
            $display("FAIL swl_b0_latency: stalls=%0d, expected 2", st);
        end
        checkWord("swl_b0_result", 16'h0020, 32'h01020304);
        doAccess(3, 16'h0023, 32'hA0B0C0D0, st, rd, fr);
        compared++;
        if (st != 2) begin
            mismatched++;
            $display("FAIL swr_b3_latency: stalls=%0d, expected 2", st);
        end
        checkWord("swr_b3_result", 16'h0020, 32'hA0B0C0D0);
        // Sweep every offset for both kinds on another word with random data.
        doAccess(1, 16'h0030, $urandom, st, rd, fr);
        for (int k = 2; k <= 3; k++) begin
            for (int b = 0; b < 4; b++) begin
                rt = $urandom;
                doAccess(k, 16'h0030 + 16'(b), rt, st, rd, fr);
                compared++;
                if (st != 2) begin
                    mismatched++;
                    $display("FAIL sweep_latency: kind=%0d b=%0d stalls=%0d, expected 2", k, b, st);
                end
                checkWord("sweep_result", 16'h0030, refMem[12]);
            end
        end
        checkDrained("boundary");
    endtask

    task automatic test_reset_abort();
        Address   = 16'h0011;
        WriteData = 32'h99999999;
        WriteEn   = 1'b1;
        WriteL    = 1'b1;
        @(negedge Clock);
        compared++;
        if (Stall !== 1'b1 || MemReadEn !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_rmw_start: Stall=%b MemReadEn=%b, expected 1 and 1", Stall, MemReadEn);
        end
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(negedge Clock);
        compared++;
        if (MemWriteEn !== 1'b0 || Stall !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_outputs: MemWriteEn=%b Stall=%b, expected 0 and 0", MemWriteEn, Stall);
        end
        WriteEn = 1'b0;
        WriteL  = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        checkWord("abort_word_kept", 16'h0010, refMem[4]);
        checkDrained("reset_abort");
    endtask

`ifdef MEMCTRL_ALIGN_CHECK_EN
    task automatic test_align();
        int          st;
        logic [31:0] rd;
        logic        fr;
        compared++;
        if (AlignErr !== 1'b0) begin
            mismatched++;
            $display("FAIL align_initial: AlignErr=%b, expected 0", AlignErr);
        end
        doAccess(0, 16'h0012, 32'h0, st, rd, fr);
        compared++;
        if (fr !== 1'b0 || st != 1 || rd !== 32'h0 || AlignErr !== 1'b1) begin
            mismatched++;
            $display("FAIL align_load: rd_strobe=%b stalls=%0d data=%h AlignErr=%b, expected 0 1 0 1",
                     fr, st, rd, AlignErr);
        end
        checkWord("align_sticky_load", 16'h0010, refMem[4]);
        compared++;
        if (AlignErr !== 1'b1) begin
            mismatched++;
            $display("FAIL align_sticky: AlignErr=%b, expected 1", AlignErr);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset     = 1'b1;
        Address   = '0;
        ReadEn    = 1'b0;
        WriteEn   = 1'b0;
        WriteL    = 1'b0;
        WriteR    = 1'b0;
        WriteData = 32'h0;
        for (int i = 0; i < 64; i++) refMem[i] = 32'h0;

        test_reset();
        test_full_store();
        test_load();
        test_swl();
        test_swr();
        test_back_to_back();
        test_boundary();
        test_reset_abort();
`ifdef MEMCTRL_ALIGN_CHECK_EN
        test_align();
`endif
        repeat (2) @(posedge Clock);
        checkDrained("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
